// File: rtl/flash_cmd_issuer.sv
// Command-port initiator for the NAND flash controller: expands one host request
// into a spaced train of cmd/start_trs words, then waits for the controller's verdict.
module flash_cmd_issuer #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 24000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [23:0] req_addr_a,
  input  logic [23:0] req_addr_b,
  output logic [31:0] cmd,
  output logic        start_trs,
  input  logic        end_erase,
  input  logic        end_read,
  input  logic        end_init_flash_addr,
  input  logic        flash_cmd_incomplete,
  input  logic        nandflash_busy_Noresponse,
  output logic        done,
  output logic [1:0]  done_status,
  output logic        busy
);

  localparam logic [2:0] OP_ERASE       = 3'd1;
  localparam logic [2:0] OP_READ        = 3'd2;
  localparam logic [2:0] OP_INIT_ADDR   = 3'd3;
  localparam logic [2:0] OP_WRITE_START = 3'd4;
  localparam logic [2:0] OP_WRITE_STOP  = 3'd5;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_INCOMPLETE = 2'd1;
  localparam logic [1:0] ST_TIMEOUT    = 2'd2;
  localparam logic [1:0] ST_BAD_REQ    = 2'd3;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [23:0] addr_a_q;
  logic [23:0] addr_b_q;
  logic [2:0]  k;
  logic [31:0] gap_cnt;
  logic [31:0] tmo_cnt;

  function automatic logic [31:0] word_of(input logic [2:0] op, input logic [2:0] idx,
                                          input logic [23:0] a, input logic [23:0] b);
    logic [15:0] payload;
    case (idx)
      3'd1:    payload = {8'h00, a[23:16]};
      3'd2:    payload = a[15:0];
      3'd3:    payload = {8'h00, b[23:16]};
      3'd4:    payload = b[15:0];
      default: payload = 16'h0000;
    endcase
    return {5'b0, op, 5'b0, idx, payload};
  endfunction

  function automatic logic [2:0] last_idx(input logic [2:0] op);
    case (op)
      OP_ERASE:              return 3'd4;
      OP_READ, OP_INIT_ADDR: return 3'd2;
      default:               return 3'd0;
    endcase
  endfunction

  logic flag_hit;
  always_comb begin
    flag_hit = 1'b0;
    case (op_q)
      OP_ERASE:     flag_hit = end_erase;
      OP_READ:      flag_hit = end_read;
      OP_INIT_ADDR: flag_hit = end_init_flash_addr;
      default:      flag_hit = 1'b0;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Outputs are loaded on the edge that enters a state, so start_trs and done
  // line up exactly with the SEND and DONE cycles.
  // NOTE: every register here is updated with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      k           <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      cmd         <= '0;
      start_trs   <= 1'b0;
      done        <= 1'b0;
      done_status <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (req_valid) begin
            op_q     <= req_op;
            addr_a_q <= req_addr_a;
            addr_b_q <= req_addr_b;
            k        <= '0;
            if (req_op >= OP_ERASE && req_op <= OP_WRITE_STOP) begin
              state     <= S_SEND;
              start_trs <= 1'b1;
              cmd       <= word_of(req_op, 3'd0, req_addr_a, req_addr_b);
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              done_status <= ST_BAD_REQ;
            end
          end
        end
        S_SEND: begin
          start_trs <= 1'b0;
          gap_cnt   <= '0;
          state     <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 32'd1;
          end else if (k != last_idx(op_q)) begin
            k         <= k + 3'd1;
            cmd       <= word_of(op_q, k + 3'd1, addr_a_q, addr_b_q);
            start_trs <= 1'b1;
            state     <= S_SEND;
          end else if (op_q == OP_WRITE_START || op_q == OP_WRITE_STOP) begin
            done        <= 1'b1;
            done_status <= ST_OK;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flag_hit) begin
            done <= 1'b1; done_status <= ST_OK;         state <= S_DONE;
          end else if (flash_cmd_incomplete) begin
            done <= 1'b1; done_status <= ST_INCOMPLETE; state <= S_DONE;
          end else if (nandflash_busy_Noresponse || tmo_cnt == TMO_LAST) begin
            done <= 1'b1; done_status <= ST_TIMEOUT;    state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_issuer.sv
// Scoreboard bench for flash_cmd_issuer: stimulus queues expected cmd words and
// done statuses; a negedge monitor pops and compares whatever the DUT presents.
module tb_flash_cmd_issuer;

  localparam int GAP = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [23:0] req_addr_a = '0;
  logic [23:0] req_addr_b = '0;
  logic [31:0] cmd;
  logic        start_trs;
  logic        end_erase = 1'b0;
  logic        end_read = 1'b0;
  logic        end_init_flash_addr = 1'b0;
  logic        flash_cmd_incomplete = 1'b0;
  logic        nandflash_busy_Noresponse = 1'b0;
  logic        done;
  logic [1:0]  done_status;
  logic        busy;

  flash_cmd_issuer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .cmd(cmd), .start_trs(start_trs),
    .end_erase(end_erase), .end_read(end_read), .end_init_flash_addr(end_init_flash_addr),
    .flash_cmd_incomplete(flash_cmd_incomplete),
    .nandflash_busy_Noresponse(nandflash_busy_Noresponse),
    .done(done), .done_status(done_status), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_trs_cyc = 0;
  int   done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_cmd(input logic [31:0] w);
    exp_t e;
    e.is_done = 1'b0; e.val = w;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] s);
    exp_t e;
    e.is_done = 1'b1; e.val = {30'd0, s};
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every start_trs word and every done pulse against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (start_trs) begin
        if (cmd[23:16] != 8'd0)
          check("trs_spacing", 32'(cyc - last_trs_cyc), 32'(GAP + 1));
        last_trs_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_cmd", cmd, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cmd_kind", {31'd0, e.is_done}, 32'd0);
          check("cmd_word", cmd, e.val);
        end
      end
      if (done) begin
        done_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_done", {30'd0, done_status}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
          check("done_status", {30'd0, done_status}, e.val);
        end
      end
    end
  end

  task automatic wait_size(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() <= n) break;
    end
    check("queue_drain", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr_a = a; req_addr_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom_range(1, 5));
    req_addr_a = 24'($urandom); req_addr_b = 24'($urandom);
    check("busy_after_accept", {30'd0, busy, req_ready}, 32'd2);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cmd", cmd, 32'd0);
    check("rst_outs", {28'd0, start_trs, done, busy, 1'b0}, 32'd0);
    check("rst_status", {30'd0, done_status}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // ERASE, with a stray incomplete pulse during the word train
    push_cmd(32'h01000000); push_cmd(32'h01010001); push_cmd(32'h01022345);
    push_cmd(32'h01030001); push_cmd(32'h010423FF); push_done(2'd0);
    issue(3'd1, 24'h012345, 24'h0123FF);
    flash_cmd_incomplete = 1'b1;
    @(negedge clk);
    flash_cmd_incomplete = 1'b0;
    wait_size(1, 200);
    repeat (10) @(negedge clk);
    end_erase = 1'b1;
    wait_size(0, 50);
    end_erase = 1'b0;

    // READ with end_read already high before WAIT
    end_read = 1'b1;
    push_cmd(32'h02000000); push_cmd(32'h020100AB); push_cmd(32'h0202CDEF); push_done(2'd0);
    issue(3'd2, 24'hABCDEF, 24'h000000);
    wait_size(0, 100);
    check("read_first_wait", 32'(done_cyc - last_trs_cyc), 32'(GAP + 2));
    end_read = 1'b0;

    // INIT_ADDR: wrong flags ignored, then incomplete
    push_cmd(32'h03000000); push_cmd(32'h0301005A); push_cmd(32'h03021234); push_done(2'd1);
    issue(3'd3, 24'h5A1234, 24'h000000);
    wait_size(1, 100);
    repeat (GAP + 1) @(negedge clk);
    end_read = 1'b1; end_erase = 1'b1;
    @(negedge clk);
    end_read = 1'b0; end_erase = 1'b0;
    repeat (3) @(negedge clk);
    flash_cmd_incomplete = 1'b1;
    wait_size(0, 50);
    flash_cmd_incomplete = 1'b0;

    // READ with no response: timeout
    push_cmd(32'h02000000); push_cmd(32'h02010012); push_cmd(32'h02023456); push_done(2'd2);
    issue(3'd2, 24'h123456, 24'h000000);
    wait_size(0, 100);
    check("timeout_latency", 32'(done_cyc - last_trs_cyc), 32'(GAP + 1 + TMO));
    check("status_held", {30'd0, done_status}, 32'd2);

    // READ with flash stuck busy: immediate status 2
    nandflash_busy_Noresponse = 1'b1;
    push_cmd(32'h02000000); push_cmd(32'h02010000); push_cmd(32'h02020001); push_done(2'd2);
    issue(3'd2, 24'h000001, 24'h000000);
    wait_size(0, 100);
    check("noresp_latency", 32'(done_cyc - last_trs_cyc), 32'(GAP + 2));
    nandflash_busy_Noresponse = 1'b0;

    // WRITE_START, WRITE_STOP, invalid op 7
    push_cmd(32'h04000000); push_done(2'd0);
    issue(3'd4, 24'hFFFFFF, 24'hFFFFFF);
    wait_size(0, 50);
    push_cmd(32'h05000000); push_done(2'd0);
    issue(3'd5, 24'h000000, 24'h000000);
    wait_size(0, 50);
    push_done(2'd3);
    issue(3'd7, 24'h000000, 24'h000000);
    wait_size(0, 20);

    // Reset while ERASE word k2 is on the bus
    push_cmd(32'h01000000); push_cmd(32'h01010011); push_cmd(32'h01021111);
    issue(3'd1, 24'h111111, 24'h222222);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0) break;
      end
    end
    check("k2_reached", 32'(exp_q.size()), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("async_rst_outs", {30'd0, start_trs, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (GAP * 3) @(negedge clk);
    check("no_done_after_rst", {30'd0, done, start_trs}, 32'd0);

    // READ after reset restarts from k0
    end_read = 1'b1;
    push_cmd(32'h02000000); push_cmd(32'h02010000); push_cmd(32'h02020102); push_done(2'd0);
    issue(3'd2, 24'h000102, 24'h000000);
    wait_size(0, 100);
    end_read = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
